// File: rtl/regfile_mp_pkg.sv
// Shared constants and init FSM encoding for the multi-port register file.
// Imported by the register file top and its scoreboard.
package regfile_mp_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_NUM_DEF  = 32;
  localparam int RD_PORTS_DEF = 2;
  localparam int WR_PORTS_DEF = 1;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback.
// A same-cycle set beats a clear because it belongs to a newer producer.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int REG_NUM  = REG_NUM_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF,
  parameter int WR_PORTS = WR_PORTS_DEF,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [WR_PORTS-1:0]    wr_en,
  input  logic [WR_PORTS*AW-1:0] wr_regid,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_regid,
  input  logic [RD_PORTS*AW-1:0] rd_regid,
  input  logic [RD_PORTS-1:0]    rd_hit,
  output logic [RD_PORTS-1:0]    rd_busy
);

  logic [REG_NUM-1:0] pending;
  logic [REG_NUM-1:0] pending_nxt;

  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < WR_PORTS; i++) begin
      if (en && wr_en[i]) begin
        pending_nxt[wr_regid[i*AW +: AW]] = 1'b0;
      end
    end
    if (en && sb_set) begin
      pending_nxt[sb_regid] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      pending_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_busy[p] = en & pending[rd_regid[p*AW +: AW]] & ~rd_hit[p];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with init sweep, write-to-read bypass
// and issue scoreboard; data bits carry no reset so storage can map to RAM.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_NUM  = REG_NUM_DEF,
  parameter int RD_PORTS = RD_PORTS_DEF,
  parameter int WR_PORTS = WR_PORTS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(REG_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       init_done,
  input  logic [WR_PORTS-1:0]        wr_en,
  input  logic [WR_PORTS*AW-1:0]     wr_regid,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data,
  input  logic [RD_PORTS*AW-1:0]     rd_regid,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  input  logic                       sb_set,
  input  logic [AW-1:0]              sb_regid
);

  logic                  state;
  logic [AW-1:0]         cnt;
  logic                  run;
  logic [WR_PORTS-1:0]   we;
  logic [RD_PORTS-1:0]   hit;
  logic [AW-1:0]         rid;
  logic [DATA_W-1:0]     val;
  logic [DATA_W-1:0]     mem [REG_NUM];

  assign run       = (state == ST_RUN);
  assign init_done = run;
  assign we        = wr_en & {WR_PORTS{run}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else if (!run) begin
      cnt <= cnt + AW'(1);
      if (cnt == AW'(REG_NUM - 1)) begin
        state <= ST_RUN;
      end
    end
  end

  // Later ports are assigned last, so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (we[i] &&
            !(ZERO_REG != 0 && wr_regid[i*AW +: AW] == '0)) begin
          mem[wr_regid[i*AW +: AW]] <= wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    hit     = '0;
    rid     = '0;
    val     = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rid = rd_regid[p*AW +: AW];
      val = mem[rid];
      for (int i = 0; i < WR_PORTS; i++) begin
        if (BYPASS != 0 && we[i] && wr_regid[i*AW +: AW] == rid) begin
          hit[p] = 1'b1;
          val    = wr_data[i*DATA_W +: DATA_W];
        end
      end
      if ((ZERO_REG != 0 && rid == '0) || !run) begin
        val = '0;
      end
      rd_data[p*DATA_W +: DATA_W] = val;
    end
  end

  regfile_scoreboard #(
    .REG_NUM  (REG_NUM),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (run),
    .wr_en    (we),
    .wr_regid (wr_regid),
    .sb_set   (sb_set),
    .sb_regid (sb_regid),
    .rd_regid (rd_regid),
    .rd_hit   (hit),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a 2R2W bypassing instance driven from a vector table,
// plus a 1R1W non-bypassing instance and reset/init corner sequences.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        init_done;
  logic [1:0]  wr_en;
  logic [9:0]  wr_regid;
  logic [63:0] wr_data;
  logic [9:0]  rd_regid;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        sb_set;
  logic [4:0]  sb_regid;

  logic        b_init_done;
  logic        b_wr_en;
  logic [4:0]  b_wr_regid;
  logic [31:0] b_wr_data;
  logic [4:0]  b_rd_regid;
  logic [31:0] b_rd_data;
  logic        b_rd_busy;
  logic        b_sb_set;
  logic [4:0]  b_sb_regid;

  regfile_mp #(
    .DATA_W(32), .REG_NUM(32), .RD_PORTS(2),
    .WR_PORTS(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .wr_en(wr_en), .wr_regid(wr_regid), .wr_data(wr_data),
    .rd_regid(rd_regid), .rd_data(rd_data), .rd_busy(rd_busy),
    .sb_set(sb_set), .sb_regid(sb_regid)
  );

  regfile_mp #(
    .DATA_W(32), .REG_NUM(32), .RD_PORTS(1),
    .WR_PORTS(1), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .init_done(b_init_done),
    .wr_en(b_wr_en), .wr_regid(b_wr_regid), .wr_data(b_wr_data),
    .rd_regid(b_rd_regid), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .sb_set(b_sb_set), .sb_regid(b_sb_regid)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wid0, wid1;
    logic [31:0] wd0, wd1;
    logic [4:0]  rid0, rid1;
    logic        sbs;
    logic [4:0]  sbid;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t tbl [15];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = '0; wr_regid = '0; wr_data = '0;
    sb_set = 1'b0; sb_regid = '0;
    b_wr_en = 1'b0; b_wr_regid = '0; b_wr_data = '0;
    b_sb_set = 1'b0; b_sb_regid = '0;
  endtask

  task automatic wait_init(input string name, input int exp);
    int n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(posedge clk);
      #1;
      if (init_done) n = k;
    end
    idle();
    chk(name, n, exp);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{2'b01, 5'd7, 5'd0, 32'h12345678, 32'h0, 5'd7, 5'd7,
                1'b0, 5'd0, 32'h12345678, 32'h12345678, 2'b00};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0,
                1'b0, 5'd0, 32'h12345678, 32'h0, 2'b00};
    tbl[2]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd0, 5'd7,
                1'b0, 5'd0, 32'h0, 32'h12345678, 2'b00};
    tbl[3]  = '{2'b11, 5'd3, 5'd3, 32'h1, 32'h2, 5'd0, 5'd3,
                1'b0, 5'd0, 32'h0, 32'h2, 2'b00};
    tbl[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd7,
                1'b0, 5'd0, 32'h2, 32'h12345678, 2'b00};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3,
                1'b1, 5'd9, 32'h0, 32'h2, 2'b00};
    tbl[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd3,
                1'b0, 5'd0, 32'h0, 32'h2, 2'b01};
    tbl[7]  = '{2'b10, 5'd0, 5'd9, 32'h0, 32'hCAFE0009, 5'd9, 5'd9,
                1'b0, 5'd0, 32'hCAFE0009, 32'hCAFE0009, 2'b00};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd7,
                1'b0, 5'd0, 32'hCAFE0009, 32'h12345678, 2'b00};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9,
                1'b1, 5'd9, 32'hCAFE0009, 32'hCAFE0009, 2'b00};
    tbl[10] = '{2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 5'd9, 5'd9,
                1'b1, 5'd9, 32'h99, 32'h99, 2'b00};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd9,
                1'b0, 5'd0, 32'h99, 32'h99, 2'b11};
    tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9,
                1'b1, 5'd0, 32'h0, 32'h99, 2'b10};
    tbl[13] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd9,
                1'b1, 5'd4, 32'h0, 32'h99, 2'b10};
    tbl[14] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd4,
                1'b0, 5'd0, 32'h99, 32'h0, 2'b11};

    idle();
    rd_regid = '0;
    b_rd_regid = '0;
    rst = 1'b1;
    #1;
    chk("reset_init_done", init_done, 1'b0);
    chk("reset_busy", rd_busy, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // writes and issues during the sweep must be dropped
    wr_en = 2'b01; wr_regid = {5'd0, 5'd5};
    wr_data = {32'h0, 32'hDEADBEEF};
    sb_set = 1'b1; sb_regid = 5'd5;
    rd_regid = {5'd5, 5'd5};
    #1;
    chk("init_rd_data", rd_data, 64'h0);
    chk("init_rd_busy", rd_busy, 2'b00);
    wait_init("init_edges", 32);
    rd_regid = {5'd0, 5'd5};
    #1;
    chk("x5_after_init", rd_data[31:0], 32'h0);
    chk("x5_not_busy", rd_busy, 2'b00);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      wr_en    = tbl[i].we;
      wr_regid = {tbl[i].wid1, tbl[i].wid0};
      wr_data  = {tbl[i].wd1, tbl[i].wd0};
      rd_regid = {tbl[i].rid1, tbl[i].rid0};
      sb_set   = tbl[i].sbs;
      sb_regid = tbl[i].sbid;
      #1;
      chk($sformatf("v%0d_data", i), rd_data, {tbl[i].e1, tbl[i].e0});
      chk($sformatf("v%0d_busy", i), rd_busy, tbl[i].eb);
      @(negedge clk);
    end
    idle();

    // reset in RUN with x4/x9 pending, then a second reset mid-sweep
    rst = 1'b1;
    #1;
    chk("run_rst_done", init_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_init("restart_edges", 32);
    rd_regid = {5'd7, 5'd4};
    #1;
    chk("reinit_data", rd_data, 64'h0);
    chk("reinit_busy", rd_busy, 2'b00);
    @(negedge clk);

    // non-bypassing instance: busy holds through writeback
    b_sb_set = 1'b1; b_sb_regid = 5'd2; b_rd_regid = 5'd2;
    @(negedge clk);
    b_sb_set = 1'b0;
    b_wr_en = 1'b1; b_wr_regid = 5'd2; b_wr_data = 32'hA5A5A5A5;
    #1;
    chk("nb_wb_data", b_rd_data, 32'h0);
    chk("nb_wb_busy", b_rd_busy, 1'b1);
    @(negedge clk);
    b_wr_en = 1'b0;
    #1;
    chk("nb_after_data", b_rd_data, 32'hA5A5A5A5);
    chk("nb_after_busy", b_rd_busy, 1'b0);
    chk("nb_init_done", b_init_done, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the current 2R1W file.
- Sits between the decode stage (reads, issue-time scoreboard marking) and the writeback stage(s) (writes).
- Adds configurable read/write port counts, per-register pending (scoreboard) tracking, and priority write-to-read bypass.
- Storage is zeroed by a post-reset init sweep, so the array can map to RAM-style storage with no reset on data bits.

Parameters:
- DATA_W, 32, register width in bits.
- REG_NUM, 32, number of architectural registers; power of two, >= 4.
- RD_PORTS, 2, number of read ports, 1..4.
- WR_PORTS, 1, number of write ports, 1..2.
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1, when 1, same-cycle write data is forwarded to matching read ports.

Ports (AW = clog2(REG_NUM)):
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- init_done  out  1  high once the init sweep has finished.
- wr_en  in  WR_PORTS  per-port write enable.
- wr_regid  in  WR_PORTS*AW  per-port destination register.
- wr_data  in  WR_PORTS*DATA_W  per-port write data.
- rd_regid  in  RD_PORTS*AW  per-port source register.
- rd_data  out  RD_PORTS*DATA_W  per-port read data (combinational).
- rd_busy  out  RD_PORTS  source register has a pending, unbypassed write.
- sb_set  in  1  issue: mark sb_regid pending.
- sb_regid  in  AW  register to mark pending.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = INIT, init counter = 0, init_done = 0, all pending bits = 0.
  - Array contents are not reset.
- FSM, two states:
  - INIT: each cycle writes 0 to register[counter], then counter increments. When counter = REG_NUM-1 the FSM moves to RUN.
  - RUN: terminal until the next rst.
- init_done:
  - Rises on the REG_NUM-th clock edge after rst deasserts; it is registered and equals (state == RUN).
  - Asserting rst mid-sweep restarts INIT from counter 0.
- During INIT:
  - wr_en and sb_set are ignored.
  - rd_data = 0 and rd_busy = 0 on all ports.
- RUN writes:
  - On a clock edge, register[wr_regid[i]] <= wr_data[i] when wr_en[i] is high.
  - Writes to register 0 are dropped when ZERO_REG = 1.
  - If both write ports target the same register, port WR_PORTS-1 (highest index) wins.
- RUN reads (combinational, zero latency). Priority, highest first:
  - rd_regid = 0 with ZERO_REG = 1 -> 0.
  - BYPASS = 1 and a matching wr_en -> the winning port's wr_data.
  - Otherwise -> stored value.
- Scoreboard:
  - pending[r] sets on the edge where sb_set is high and sb_regid = r.
  - pending[r] clears on the edge where any wr_en targets r.
  - Set and clear of the same r in the same cycle: set wins (a newer producer has issued).
  - sb_set to register 0 is ignored when ZERO_REG = 1.
- rd_busy[p] = pending[rd_regid[p]] AND NOT (BYPASS AND any wr_en matching rd_regid[p]).
- With BYPASS = 0, rd_busy stays high through the writeback cycle and drops the following cycle.
- The array is never reset outside INIT; data from a previous run is not visible after init_done.

Decomposition:
- Shared constants and macros go in core.svh, as the existing RF_RANGE/DATA_RANGE style:
  - REG_NUM, DATA_W, AW.
  - The read/write port-count defaults.
- FSM state enum goes in core.svh: INIT and RUN.
- Natural sub-module: regfile_scoreboard.
  - Contents: pending bit vector, set/clear priority logic, busy lookup per read port.
  - Parameters: REG_NUM, RD_PORTS, WR_PORTS, ZERO_REG.
- Storage, init FSM and the bypass muxes stay in regfile_mp.

Test Plan:
- Init sweep: rst pulse, then deassert -> init_done low for exactly 32 edges, then high. A wr_en of 0xDEADBEEF to x5 during INIT -> x5 still reads 0 after init.
- Write then read: write x7 = 0x12345678 -> same-cycle rd_data = 0x12345678 (bypass). The next cycle also reads 0x12345678 from storage. Write x0 = 0xFFFFFFFF -> x0 reads 0.
- Dual write port conflict (WR_PORTS = 2): port0 writes x3 = 0x1, port1 writes x3 = 0x2 in the same cycle -> same-cycle read and later read both return 0x2.
- Scoreboard: sb_set x9 -> rd_busy = 1 on the next cycle. Writeback of x9 -> rd_busy = 0 that cycle (BYPASS = 1) and pending cleared. Same-cycle sb_set x9 plus wr x9 -> x9 stays pending.
- Reset mid-operation: assert rst at init counter 10 -> counter restarts, init_done takes a further 32 edges. Assert rst in RUN with x4 pending -> pending cleared and x4 reads 0 after re-init.
- BYPASS = 0 configuration: write x2 = 0xA5A5A5A5 -> same-cycle rd_data returns old value 0. rd_busy stays high on the write cycle and drops on the next cycle.
